// File: rtl/cgia_line_shifter.sv
// cgia_line_shifter
//   Read side of the CGIA line-buffer path. Two ping-pong line buffers:
//   the fetcher writes the next scanline into the back buffer while the
//   front buffer is serialised MSB-first, one 1bpp pixel per clock.
//   Front/back roles swap on every HSYNC rising edge.
//
// Ports
//   clk_i     system clock, rising edge
//   reset_i   asynchronous active-high reset
//   hsync_i   CRTC HSYNC; rising edge swaps buffers and aborts the line
//   den_i     display enable; low aborts an active line
//   dstart_i  start-of-active-line pulse
//   we_i      fetcher write strobe (back buffer only)
//   wadr_i    fetcher word address within the line
//   wdat_i    fetcher word data
//   pix_o     current pixel
//   pvalid_o  pix_o carries an active pixel
//   bank_o    index of the current front (read) buffer
module cgia_line_shifter #(
  parameter int WORDS = 40,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          hsync_i,
  input  logic          den_i,
  input  logic          dstart_i,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [15:0]   wdat_i,
  output logic          pix_o,
  output logic          pvalid_o,
  output logic          bank_o
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_PRIME = 2'd1;
  localparam logic [1:0]    ST_SHIFT = 2'd2;
  localparam logic [AW:0]   WORDS_W   = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  // Both banks are sized to the full address space; out-of-range writes
  // are filtered explicitly so unused rows are never written.
  logic [15:0]   line_mem [0:1][0:(1<<AW)-1];
  logic [15:0]   rdat_q;

  logic [1:0]    state_q,  state_d;
  logic          hs_q;
  logic          bank_q,   bank_d;
  logic          pix_q,    pix_d;
  logic          pvalid_q, pvalid_d;
  logic [AW-1:0] radr_q,   radr_d;
  logic [AW-1:0] wcnt_q,   wcnt_d;
  logic [3:0]    bcnt_q,   bcnt_d;
  logic [15:0]   shreg_q,  shreg_d;
  logic          prime_q,  prime_d;
  logic          hs_rise_s;
  logic          wr_ok_s;

  assign hs_rise_s = hsync_i & ~hs_q;
  assign wr_ok_s   = we_i & ({1'b0, wadr_i} < WORDS_W);

  // Line RAM: back-buffer write port and 1-cycle front-buffer read port.
  // Using the pre-swap bank on a swap edge lands the write in the new front.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      line_mem[~bank_q][wadr_i] <= wdat_i;
    end
    rdat_q <= line_mem[bank_q][radr_q];
  end

  // Next-state logic: HSYNC swap beats display-enable abort beats the FSM.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    pix_d    = pix_q;
    pvalid_d = pvalid_q;
    radr_d   = radr_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    prime_d  = prime_q;
    if (hs_rise_s) begin
      bank_d   = ~bank_q;
      state_d  = ST_IDLE;
      pix_d    = 1'b0;
      pvalid_d = 1'b0;
    end else if ((state_q != ST_IDLE) && !den_i) begin
      state_d  = ST_IDLE;
      pix_d    = 1'b0;
      pvalid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pix_d    = 1'b0;
          pvalid_d = 1'b0;
          if (dstart_i && den_i) begin
            radr_d  = '0;
            wcnt_d  = '0;
            prime_d = 1'b0;
            state_d = ST_PRIME;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRIME: begin
          // First edge presents address 0 to the RAM; the second edge
          // finds word 0 in rdat_q and starts shifting.
          if (!prime_q) begin
            prime_d = 1'b1;
          end else begin
            state_d  = ST_SHIFT;
            shreg_d  = rdat_q;
            radr_d   = radr_q + ONE_A;
            bcnt_d   = 4'd15;
            pvalid_d = 1'b1;
            pix_d    = rdat_q[15];
          end
        end
        ST_SHIFT: begin
          if (bcnt_q != 4'd0) begin
            shreg_d = {shreg_q[14:0], 1'b0};
            pix_d   = shreg_q[14];
            bcnt_d  = bcnt_q - 4'd1;
          end else if (wcnt_q != LAST_WORD) begin
            // rdat_q already holds the next word: reload without a gap.
            shreg_d = rdat_q;
            pix_d   = rdat_q[15];
            radr_d  = radr_q + ONE_A;
            wcnt_d  = wcnt_q + ONE_A;
            bcnt_d  = 4'd15;
          end else begin
            state_d  = ST_IDLE;
            pix_d    = 1'b0;
            pvalid_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          pix_d    = 1'b0;
          pvalid_d = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      hs_q     <= 1'b0;
      bank_q   <= 1'b0;
      pix_q    <= 1'b0;
      pvalid_q <= 1'b0;
      radr_q   <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= 4'd0;
      shreg_q  <= 16'h0000;
      prime_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hsync_i;
      bank_q   <= bank_d;
      pix_q    <= pix_d;
      pvalid_q <= pvalid_d;
      radr_q   <= radr_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      prime_q  <= prime_d;
    end
  end

  assign pix_o    = pix_q;
  assign pvalid_o = pvalid_q;
  assign bank_o   = bank_q;

endmodule

// File: tb/tb_cgia_line_shifter.sv
// tb_cgia_line_shifter
//   Directed bench for cgia_line_shifter with WORDS=2. A pixel-index model
//   predicts pix/pvalid/bank every cycle; literal line images pin the model.
module tb_cgia_line_shifter;

  localparam int WORDS = 2;
  localparam int AW    = 6;
  localparam int NPIX  = 16 * WORDS;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          hsync_i = 1'b0;
  logic          den_i = 1'b0;
  logic          dstart_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] wadr_i = '0;
  logic [15:0]   wdat_i = 16'h0000;
  logic          pix_o;
  logic          pvalid_o;
  logic          bank_o;

  int n_checks = 0;
  int n_fail   = 0;

  cgia_line_shifter #(.WORDS(WORDS), .AW(AW)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .hsync_i  (hsync_i),
    .den_i    (den_i),
    .dstart_i (dstart_i),
    .we_i     (we_i),
    .wadr_i   (wadr_i),
    .wdat_i   (wdat_i),
    .pix_o    (pix_o),
    .pvalid_o (pvalid_o),
    .bank_o   (bank_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is a pixel index: busy counts edges since the start was
  // accepted; pixel (cnt-2) of the front line is shown while valid.
  logic [15:0] m_mem [0:1][0:WORDS-1];
  logic        m_bank, m_hs, m_busy, m_pix, m_valid;
  int          m_cnt;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_bank = 1'b0; m_hs = 1'b0; m_busy = 1'b0;
      m_pix = 1'b0; m_valid = 1'b0; m_cnt = 0;
    end else begin
      logic rise;
      rise = hsync_i && !m_hs;
      m_hs = hsync_i;
      if (we_i && (int'(wadr_i) < WORDS)) m_mem[!m_bank][int'(wadr_i)] = wdat_i;
      if (rise) begin
        m_bank = !m_bank; m_busy = 1'b0; m_valid = 1'b0; m_pix = 1'b0;
      end else if (m_busy && !den_i) begin
        m_busy = 1'b0; m_valid = 1'b0; m_pix = 1'b0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt - 2 >= NPIX) begin
          m_busy = 1'b0; m_valid = 1'b0; m_pix = 1'b0;
        end else if (m_cnt >= 2) begin
          logic [15:0] w;
          w = m_mem[m_bank][(m_cnt - 2) / 16];
          m_valid = 1'b1;
          m_pix = w[15 - ((m_cnt - 2) % 16)];
        end else begin
          m_valid = 1'b0; m_pix = 1'b0;
        end
      end else if (dstart_i && den_i) begin
        m_busy = 1'b1; m_cnt = 0; m_valid = 1'b0; m_pix = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a pixel capture log.
  logic [31:0] cap = 32'h0;
  int          cap_n = 0;
  always @(posedge clk_i) begin
    #1;
    chk("cyc_pvalid", {31'h0, pvalid_o}, {31'h0, m_valid});
    chk("cyc_pix",    {31'h0, pix_o},    {31'h0, m_pix});
    chk("cyc_bank",   {31'h0, bank_o},   {31'h0, m_bank});
    if (pvalid_o) begin
      cap = {cap[30:0], pix_o};
      cap_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
    we_i = 1'b1; wadr_i = a; wdat_i = d;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic hsync_pulse();
    hsync_i = 1'b1;
    @(negedge clk_i);
    hsync_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Returns with edge E0 just past.
  task automatic start_line();
    dstart_i = 1'b1;
    @(negedge clk_i);
    dstart_i = 1'b0;
  endtask

  int base_n;

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_pvalid", {31'h0, pvalid_o}, 32'h0);
    chk("reset_bank",   {31'h0, bank_o},   32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Basic line
    write_word(6'd0, 16'hA5F0);
    write_word(6'd1, 16'h0F0F);
    hsync_pulse();
    chk("swap_bank1", {31'h0, bank_o}, 32'h1);
    den_i = 1'b1;
    base_n = cap_n;
    start_line();
    @(negedge clk_i);
    chk("lat_e1_invalid", {31'h0, pvalid_o}, 32'h0);
    @(negedge clk_i);
    chk("lat_e2_valid", {31'h0, pvalid_o}, 32'h1);
    // Ping-pong: fill the back buffer with ones during the line.
    write_word(6'd0, 16'hFFFF);
    write_word(6'd1, 16'hFFFF);
    repeat (36) @(negedge clk_i);
    chk("basic_count", cap_n - base_n, NPIX);
    chk("basic_image", cap, 32'hA5F00F0F);

    // Ping-pong isolation: the other bank now holds all ones.
    hsync_pulse();
    chk("swap_bank0", {31'h0, bank_o}, 32'h0);
    base_n = cap_n;
    start_line();
    repeat (40) @(negedge clk_i);
    chk("pp_count", cap_n - base_n, NPIX);
    chk("pp_image", cap, 32'hFFFFFFFF);

    // Gating: start without display enable is ignored.
    den_i = 1'b0;
    base_n = cap_n;
    start_line();
    repeat (6) @(negedge clk_i);
    chk("gate_noden", cap_n - base_n, 0);

    // Drop den at pixel 5.
    den_i = 1'b1;
    base_n = cap_n;
    start_line();
    repeat (7) @(negedge clk_i);
    chk("den_pix5_valid", {31'h0, pvalid_o}, 32'h1);
    den_i = 1'b0;
    @(negedge clk_i);
    chk("den_abort", {31'h0, pvalid_o}, 32'h0);
    chk("den_abort_count", cap_n - base_n, 6);
    den_i = 1'b1;
    @(negedge clk_i);

    // Second dstart mid-line does not restart.
    base_n = cap_n;
    start_line();
    repeat (12) @(negedge clk_i);
    start_line();
    repeat (40) @(negedge clk_i);
    chk("norestart_count", cap_n - base_n, NPIX);
    chk("norestart_image", cap, 32'hFFFFFFFF);

    // HSYNC abort at pixel 10 with a write colliding on the swap edge.
    start_line();
    repeat (12) @(negedge clk_i);
    hsync_i = 1'b1; we_i = 1'b1; wadr_i = 6'd0; wdat_i = 16'h1234;
    @(negedge clk_i);
    hsync_i = 1'b0; we_i = 1'b0;
    chk("hs_abort_valid", {31'h0, pvalid_o}, 32'h0);
    chk("hs_abort_bank",  {31'h0, bank_o},   32'h1);
    @(negedge clk_i);
    base_n = cap_n;
    start_line();
    repeat (40) @(negedge clk_i);
    chk("collision_count", cap_n - base_n, NPIX);
    chk("collision_image", cap, 32'h12340F0F);

    // Out-of-range writes into the back buffer are dropped.
    write_word(6'd2, 16'h0000);
    write_word(6'd63, 16'h0000);
    base_n = cap_n;
    start_line();
    repeat (40) @(negedge clk_i);
    chk("oor_front_image", cap, 32'h12340F0F);
    hsync_pulse();
    base_n = cap_n;
    start_line();
    repeat (40) @(negedge clk_i);
    chk("oor_back_count", cap_n - base_n, NPIX);
    chk("oor_back_image", cap, 32'hFFFFFFFF);

    // Asynchronous reset mid-line with bank 1 in front.
    hsync_pulse();
    chk("pre_reset_bank", {31'h0, bank_o}, 32'h1);
    start_line();
    repeat (8) @(negedge clk_i);
    chk("pre_reset_valid", {31'h0, pvalid_o}, 32'h1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_pix",    {31'h0, pix_o},    32'h0);
    chk("async_pvalid", {31'h0, pvalid_o}, 32'h0);
    chk("async_bank",   {31'h0, bank_o},   32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("post_reset_idle", {31'h0, pvalid_o}, 32'h0);
    base_n = cap_n;
    start_line();
    repeat (40) @(negedge clk_i);
    chk("post_reset_image", cap, 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
